// File: rtl/trim_ctx_sequencer.sv
// Context sequencer for the trim stage: holds pending crop/scale contexts
// and applies them to the trim outputs at frame boundaries.
module trim_ctx_sequencer #(
   parameter int unsigned CTX_DEPTH = 2
) (
   input  logic        aclk,
   input  logic        aclk_reset,
   input  logic        aclk_grab_queue_en,
   input  logic        aclk_ctx_wr,
   input  logic [2:0]  aclk_ctx_pixel_width,
   input  logic        aclk_ctx_x_crop_en,
   input  logic [12:0] aclk_ctx_x_start,
   input  logic [12:0] aclk_ctx_x_size,
   input  logic [3:0]  aclk_ctx_x_scale,
   input  logic        aclk_ctx_x_reverse,
   input  logic        aclk_ctx_y_roi_en,
   input  logic [12:0] aclk_ctx_y_start,
   input  logic [12:0] aclk_ctx_y_size,
   input  logic        aclk_tvalid,
   input  logic        aclk_tready,
   input  logic [3:0]  aclk_tuser,
   output logic [2:0]  aclk_pixel_width,
   output logic        aclk_x_crop_en,
   output logic [12:0] aclk_x_start,
   output logic [12:0] aclk_x_size,
   output logic [3:0]  aclk_x_scale,
   output logic        aclk_x_reverse,
   output logic        aclk_y_roi_en,
   output logic [12:0] aclk_y_start,
   output logic [12:0] aclk_y_size,
   output logic [1:0]  aclk_load_context,
   output logic [2:0]  aclk_ctx_level,
   output logic        aclk_ctx_full,
   output logic        aclk_ctx_overflow,
   output logic        aclk_ctx_underrun,
   output logic        aclk_frame_active
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FRAME} state_t;

   localparam logic [61:0] RESET_CTX = {3'd1, 59'd0};

   state_t      state, state_n;
   logic [61:0] wr_word, active, slot, apply_word;
   logic [61:0] mem [4];
   logic [1:0]  rd_ptr, wr_ptr;
   logic [2:0]  count;
   logic        slot_full, mode_r, applied;
   logic        beat, sof, eof, flush, q_full;
   logic        apply_q, apply_i, apply, push, overflow_now, fresh, frame_end;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(CTX_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   assign wr_word = {aclk_ctx_pixel_width, aclk_ctx_x_crop_en, aclk_ctx_x_start,
                     aclk_ctx_x_size, aclk_ctx_x_scale, aclk_ctx_x_reverse,
                     aclk_ctx_y_roi_en, aclk_ctx_y_start, aclk_ctx_y_size};

   assign {aclk_pixel_width, aclk_x_crop_en, aclk_x_start, aclk_x_size, aclk_x_scale,
           aclk_x_reverse, aclk_y_roi_en, aclk_y_start, aclk_y_size} = active;

   assign aclk_ctx_level = mode_r ? count : {2'b00, slot_full};
   assign aclk_ctx_full  = (aclk_ctx_level == 3'(CTX_DEPTH));

   always_comb begin
      beat         = aclk_tvalid & aclk_tready;
      sof          = beat & aclk_tuser[0];
      eof          = beat & aclk_tuser[1];
      flush        = (aclk_grab_queue_en != mode_r);
      q_full       = (count == 3'(CTX_DEPTH));
      apply_q      = !flush && aclk_grab_queue_en && state == S_IDLE && count != 3'd0 && !sof;
      apply_i      = !flush && !aclk_grab_queue_en && state != S_FRAME && slot_full;
      apply        = apply_q | apply_i;
      apply_word   = aclk_grab_queue_en ? mem[rd_ptr] : slot;
      // A pop in the same cycle frees the slot the write needs
      push         = !flush && aclk_grab_queue_en && aclk_ctx_wr && (!q_full || apply_q);
      overflow_now = !flush && aclk_grab_queue_en && aclk_ctx_wr && q_full && !apply_q;
      fresh        = sof && state != S_FRAME &&
                     (state == S_ARMED || (!aclk_grab_queue_en && (applied || apply)));
      frame_end    = eof && (state == S_FRAME || sof);

      state_n = state;
      case (state)
         S_IDLE:  if (sof) state_n = eof ? S_IDLE : S_FRAME;
                  else if (apply_q) state_n = S_ARMED;
         S_ARMED: if (sof) state_n = eof ? S_IDLE : S_FRAME;
         S_FRAME: if (eof) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      mode_r <= aclk_grab_queue_en;
      if (aclk_reset) begin
         state             <= S_IDLE;
         count             <= '0;
         rd_ptr            <= '0;
         wr_ptr            <= '0;
         slot_full         <= 1'b0;
         applied           <= 1'b0;
         active            <= RESET_CTX;
         aclk_load_context <= '0;
         aclk_ctx_overflow <= 1'b0;
         aclk_ctx_underrun <= 1'b0;
         aclk_frame_active <= 1'b0;
      end else begin
         state             <= state_n;
         aclk_frame_active <= (state_n == S_FRAME);
         aclk_load_context <= {fresh, apply};
         aclk_ctx_overflow <= overflow_now;
         aclk_ctx_underrun <= aclk_grab_queue_en && state == S_IDLE && sof;
         applied           <= (applied | apply) & ~frame_end;
         if (apply) active <= apply_word;

         if (flush) begin
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            slot_full <= 1'b0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= wr_word;
               wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (apply_q) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + 3'(push) - 3'(apply_q);
            if (!aclk_grab_queue_en) begin
               if (aclk_ctx_wr) begin
                  slot      <= wr_word;
                  slot_full <= 1'b1;
               end else if (apply_i) begin
                  slot_full <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_trim_ctx_sequencer.sv
// Bench for trim_ctx_sequencer: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_trim_ctx_sequencer;

   localparam int unsigned DEPTH = 2;
   localparam int IDLE = 0, ARMED = 1, FRAME = 2;
   localparam logic [61:0] RESET_CTX = {3'd1, 59'd0};

   logic        aclk = 1'b0;
   logic        rst = 1'b1, qen = 1'b1, wr = 1'b0;
   logic        tvalid = 1'b0, tready = 1'b0;
   logic [3:0]  tuser = '0;
   logic [61:0] in_ctx = '0;

   logic [2:0]  c_pw;  logic c_xc;  logic [12:0] c_xs, c_xz;  logic [3:0] c_sc;
   logic        c_rv, c_yr;  logic [12:0] c_ys, c_yz;
   logic [2:0]  pixel_width;  logic x_crop_en;  logic [12:0] x_start, x_size;
   logic [3:0]  x_scale;  logic x_reverse, y_roi_en;  logic [12:0] y_start, y_size;
   logic [1:0]  load_context;
   logic [2:0]  ctx_level;
   logic        ctx_full, ctx_overflow, ctx_underrun, frame_active;
   logic [61:0] dut_ctx;

   assign {c_pw, c_xc, c_xs, c_xz, c_sc, c_rv, c_yr, c_ys, c_yz} = in_ctx;
   assign dut_ctx = {pixel_width, x_crop_en, x_start, x_size, x_scale,
                     x_reverse, y_roi_en, y_start, y_size};

   always #5 aclk = ~aclk;

   trim_ctx_sequencer #(.CTX_DEPTH(DEPTH)) dut (
      .aclk(aclk), .aclk_reset(rst), .aclk_grab_queue_en(qen), .aclk_ctx_wr(wr),
      .aclk_ctx_pixel_width(c_pw), .aclk_ctx_x_crop_en(c_xc), .aclk_ctx_x_start(c_xs),
      .aclk_ctx_x_size(c_xz), .aclk_ctx_x_scale(c_sc), .aclk_ctx_x_reverse(c_rv),
      .aclk_ctx_y_roi_en(c_yr), .aclk_ctx_y_start(c_ys), .aclk_ctx_y_size(c_yz),
      .aclk_tvalid(tvalid), .aclk_tready(tready), .aclk_tuser(tuser),
      .aclk_pixel_width(pixel_width), .aclk_x_crop_en(x_crop_en), .aclk_x_start(x_start),
      .aclk_x_size(x_size), .aclk_x_scale(x_scale), .aclk_x_reverse(x_reverse),
      .aclk_y_roi_en(y_roi_en), .aclk_y_start(y_start), .aclk_y_size(y_size),
      .aclk_load_context(load_context), .aclk_ctx_level(ctx_level), .aclk_ctx_full(ctx_full),
      .aclk_ctx_overflow(ctx_overflow), .aclk_ctx_underrun(ctx_underrun),
      .aclk_frame_active(frame_active)
   );

   int n_vec = 0, n_err = 0;

   // reference model state
   int          m_state = IDLE;
   logic [61:0] mq[$];
   logic [61:0] m_slot = '0, m_active = RESET_CTX;
   bit          m_slot_full = 0, m_flag = 0, m_mode = 1;
   logic [1:0]  e_load = '0;
   bit          e_ovf = 0, e_und = 0;
   int          e_level = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit sof, eof, ap, fresh;
      logic [61:0] aw;
      if (rst) begin
         m_state = IDLE; mq.delete(); m_slot_full = 0; m_flag = 0;
         m_active = RESET_CTX; e_load = '0; e_ovf = 0; e_und = 0;
         m_mode = qen; e_level = 0;
         return;
      end
      sof = tvalid && tready && tuser[0];
      eof = tvalid && tready && tuser[1];
      ap = 0; aw = '0; e_ovf = 0;
      if (qen == m_mode) begin
         if (qen && m_state == IDLE && mq.size() > 0 && !sof) begin
            ap = 1; aw = mq.pop_front();
         end else if (!qen && m_state != FRAME && m_slot_full) begin
            ap = 1; aw = m_slot; m_slot_full = 0;
         end
         if (wr) begin
            if (qen) begin
               if (mq.size() < DEPTH) mq.push_back(in_ctx);
               else e_ovf = 1;
            end else begin
               m_slot = in_ctx; m_slot_full = 1;
            end
         end
      end else begin
         mq.delete(); m_slot_full = 0;
      end
      e_und = qen && m_state == IDLE && sof;
      fresh = sof && m_state != FRAME && (m_state == ARMED || (!qen && (m_flag || ap)));
      m_flag = (m_flag || ap) && !(eof && (m_state == FRAME || sof));
      if (ap) m_active = aw;
      e_load = {fresh, ap};
      if (m_state != FRAME && sof)       m_state = eof ? IDLE : FRAME;
      else if (m_state == FRAME && eof)  m_state = IDLE;
      else if (ap && qen)                m_state = ARMED;
      m_mode  = qen;
      e_level = m_mode ? mq.size() : int'(m_slot_full);
   endtask

   task automatic tick();
      @(posedge aclk);
      model_step();
      #1;
      chk("context",  64'(dut_ctx), 64'(m_active));
      chk("load",     64'(load_context), 64'(e_load));
      chk("level",    64'(ctx_level), 64'(e_level));
      chk("full",     64'(ctx_full), 64'(e_level == DEPTH));
      chk("overflow", 64'(ctx_overflow), 64'(e_ovf));
      chk("underrun", 64'(ctx_underrun), 64'(e_und));
      chk("frame",    64'(frame_active), 64'(m_state == FRAME));
   endtask

   task automatic beat(input logic [3:0] u);
      tvalid = 1; tready = 1; tuser = u;
   endtask
   task automatic idle_bus();
      tvalid = 0; tready = 0; tuser = '0;
   endtask

   logic [61:0] ca, cb, cc, cd, ce, cf, cg;

   initial begin
      ca = {3'd2, 1'b0, 13'd16, 13'd128, 4'd0, 1'b0, 1'b0, 13'd0, 13'd0};
      cb = {3'd3, 1'b1, 13'd100, 13'd200, 4'd1, 1'b0, 1'b1, 13'd5, 13'd50};
      cc = {3'd4, 1'b0, 13'd300, 13'd400, 4'd2, 1'b1, 1'b0, 13'd6, 13'd60};
      cd = {3'd5, 1'b1, 13'd500, 13'd600, 4'd3, 1'b0, 1'b1, 13'd7, 13'd70};
      ce = {3'd6, 1'b1, 13'd700, 13'd800, 4'd4, 1'b1, 1'b1, 13'd8, 13'd80};
      cf = {3'd1, 1'b0, 13'd1, 13'd2, 4'd5, 1'b1, 1'b0, 13'd9, 13'd90};
      cg = {3'd7, 1'b1, 13'd3, 13'd4, 4'd6, 1'b0, 1'b0, 13'd10, 13'd99};

      // reset state
      tick(); tick();
      chk("rst_pixel_width", 64'(pixel_width), 64'd1);
      chk("rst_level", 64'(ctx_level), 64'd0);
      rst = 0;

      // queued, empty: two-cycle latency then fresh-frame pulse
      in_ctx = ca; wr = 1; tick(); wr = 0;
      chk("q_level_after_wr", 64'(ctx_level), 64'd1);
      chk("q_no_load_yet", 64'(load_context), 64'd0);
      tick();
      chk("q_x_start", 64'(x_start), 64'd16);
      chk("q_x_size", 64'(x_size), 64'd128);
      chk("q_apply_pulse", 64'(load_context), 64'd1);
      tick();
      chk("q_apply_once", 64'(load_context), 64'd0);
      beat(4'b0001); tick();
      chk("q_fresh_pulse", 64'(load_context), 64'd2);
      chk("q_frame_on", 64'(frame_active), 64'd1);
      beat(4'b0000); tick(); beat(4'b0010); tick(); idle_bus();
      chk("q_frame_off", 64'(frame_active), 64'd0);

      // SOF without tready is not a beat
      tvalid = 1; tready = 0; tuser = 4'b0001; tick();
      chk("nobeat_frame", 64'(frame_active), 64'd0);
      tready = 1; tick();
      chk("beat_frame", 64'(frame_active), 64'd1);
      chk("beat_underrun", 64'(ctx_underrun), 64'd1);
      beat(4'b0010); tick(); idle_bus(); tick();

      // three writes into depth-2 queue, fourth overflows
      in_ctx = cb; wr = 1; tick();
      in_ctx = cc; tick();
      chk("q3_apply_b", 64'(dut_ctx), 64'(cb));
      in_ctx = cd; tick();
      chk("q3_level2", 64'(ctx_level), 64'd2);
      chk("q3_full", 64'(ctx_full), 64'd1);
      in_ctx = ce; tick(); wr = 0;
      chk("q3_overflow", 64'(ctx_overflow), 64'd1);
      beat(4'b0001); tick(); beat(4'b0010); tick(); idle_bus();
      chk("q3_frame1_b", 64'(dut_ctx), 64'(cb));
      tick();
      chk("q3_apply_c", 64'(dut_ctx), 64'(cc));
      beat(4'b0001); tick(); beat(4'b0010); tick(); idle_bus(); tick();
      chk("q3_apply_d", 64'(dut_ctx), 64'(cd));
      beat(4'b0011); tick(); idle_bus(); tick();
      beat(4'b0001); tick();
      chk("q3_underrun", 64'(ctx_underrun), 64'd1);
      beat(4'b0010); tick(); idle_bus();

      // immediate mode: writes during FRAME wait for EOF, last one wins
      qen = 0; tick(); tick();
      beat(4'b0001); tick(); idle_bus();
      in_ctx = cf; wr = 1; tick();
      in_ctx = cg; tick(); wr = 0;
      chk("imm_hold1", 64'(dut_ctx), 64'(cd));
      beat(4'b0010); tick(); idle_bus();
      chk("imm_hold_eof", 64'(dut_ctx), 64'(cd));
      tick();
      chk("imm_apply_last", 64'(dut_ctx), 64'(cg));
      chk("imm_apply_pulse", 64'(load_context), 64'd1);
      tick();

      // mode toggle flushes pending, keeps active context
      qen = 1; tick();
      in_ctx = ca; wr = 1; tick();
      in_ctx = cb; tick(); in_ctx = cc; tick(); wr = 0;
      chk("flush_pre_level", 64'(ctx_level), 64'd2);
      qen = 0; tick();
      chk("flush_level", 64'(ctx_level), 64'd0);
      chk("flush_ctx", 64'(dut_ctx), 64'(ca));

      // reset mid-frame
      beat(4'b0001); tick(); idle_bus();
      chk("mid_frame", 64'(frame_active), 64'd1);
      rst = 1; tick(); rst = 0;
      chk("rst_frame", 64'(frame_active), 64'd0);
      chk("rst_ctx", 64'(dut_ctx), 64'(RESET_CTX));

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst    = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 149) == 0) qen = ~qen;
         wr     = ($urandom_range(0, 3) == 0);
         in_ctx = {$urandom, $urandom};
         tvalid = ($urandom_range(0, 3) != 0);
         tready = ($urandom_range(0, 3) != 0);
         tuser  = {2'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/trim_ctx_sequencer.md
TRIM_CTX_SEQUENCER -- requirements
Module: trim_ctx_sequencer

Interface
REQ-001 Parameter CTX_DEPTH, default 2: pending-context queue depth; legal values 1..4.
REQ-002 aclk  in  1  sole clock; all logic on rising edge.
REQ-003 aclk_reset  in  1  reset; synchronous, active-high.
REQ-004 aclk_grab_queue_en  in  1  1 = queued mode (one context per frame); 0 = immediate mode.
REQ-005 aclk_ctx_wr  in  1  one-cycle strobe that writes the aclk_ctx_* fields below.
REQ-006 aclk_ctx_pixel_width[2:0], aclk_ctx_x_crop_en, aclk_ctx_x_start[12:0], aclk_ctx_x_size[12:0], aclk_ctx_x_scale[3:0], aclk_ctx_x_reverse, aclk_ctx_y_roi_en, aclk_ctx_y_start[12:0], aclk_ctx_y_size[12:0]  in  (widths as listed)  context fields; the fields together form one 62-bit context word.
REQ-007 aclk_tvalid, aclk_tready  in  1  monitored trim input-stream handshake.
REQ-008 aclk_tuser  in  4  monitored sync bits: [0] SOF, [1] EOF, [2] SOL, [3] EOL.
REQ-009 aclk_pixel_width, aclk_x_crop_en, aclk_x_start, aclk_x_size, aclk_x_scale, aclk_x_reverse, aclk_y_roi_en, aclk_y_start, aclk_y_size  out  (same widths as REQ-006)  active context driven to trim.
REQ-010 aclk_load_context  out  2  [0] apply pulse; [1] fresh-frame pulse.
REQ-011 aclk_ctx_level  out  3  number of pending contexts.
REQ-012 aclk_ctx_full  out  1  aclk_ctx_level == CTX_DEPTH.
REQ-013 aclk_ctx_overflow, aclk_ctx_underrun  out  1  one-cycle error pulses.
REQ-014 aclk_frame_active  out  1  high while the FSM is in FRAME.

Function
REQ-015 Beat definition: a beat is a cycle with aclk_tvalid=1 and aclk_tready=1; SOF and EOF are qualified by a beat only.
REQ-016 FSM states and transitions:
 - IDLE -> ARMED on apply (queued mode only).
 - IDLE -> FRAME on SOF beat.
 - ARMED -> FRAME on SOF beat.
 - FRAME -> IDLE on EOF beat.
 - A single beat carrying both SOF and EOF returns the FSM to IDLE.
REQ-017 Queued mode: a pending FIFO holds contexts; aclk_ctx_wr pushes one.
REQ-018 Queued mode apply: pop and apply when state == IDLE, level > 0 and no SOF beat in the current cycle; state -> ARMED.
REQ-019 Queued mode limits:
 - At most one apply per frame.
 - No apply occurs in ARMED or FRAME.
REQ-020 Immediate mode write storage: a single slot is used and each write overwrites it; aclk_ctx_level saturates at 1.
REQ-021 Immediate mode apply:
 - Applied whenever state != FRAME and the slot is full.
 - A write landing during FRAME is applied in the cycle after the EOF beat.
REQ-022 Apply timing: the registered outputs update on the apply edge and aclk_load_context[0] pulses for exactly that cycle.
REQ-023 Latency: a write in IDLE with an empty queue is visible on the outputs 2 cycles after the aclk_ctx_wr cycle.
REQ-024 aclk_load_context[1] pulses on the SOF beat when the FSM is in ARMED, or in immediate mode when an apply occurred since the last EOF.
REQ-025 Underrun: an SOF beat in IDLE in queued mode pulses aclk_ctx_underrun; the frame runs with the current active context.
REQ-026 Overflow: a write while full with no pop in the same cycle is dropped and aclk_ctx_overflow pulses; if a pop occurs in the same cycle, the write is accepted and the level is unchanged.
REQ-027 Mode change: any change of aclk_grab_queue_en (detected on a registered copy) flushes the pending entries the next cycle (level -> 0); the active context and the FSM state are retained.
REQ-028 Field handling: fields are copied unmodified, with no range checking; aclk_x_stop is not computed here.
REQ-029 Output stability: active outputs never change while in FRAME.

Reset
REQ-030 While aclk_reset=1, on each edge the block sets:
 - FSM -> IDLE; FIFO and slot empty; all pulses 0.
 - pixel_width=1; all other context outputs 0; aclk_frame_active=0.
REQ-031 Reset asserted mid-frame aborts the frame; after reset release the next beat is treated per IDLE rules.

Verification
REQ-032 Queued, empty: write x_start=16, x_size=128 -> outputs updated 2 cycles later; load_context[0] pulses once; state ARMED; next SOF beat -> load_context[1]=1.
REQ-033 Queued, 3 writes (A,B,C) with CTX_DEPTH=2 in IDLE -> A applied; B queued; C accepted (level 2 after A pop); a 4th write -> overflow pulse; frames 1, 2, 3 use A, B, C; an SOF after C with queue empty -> underrun pulse.
REQ-034 Immediate mode: write x_reverse=1 mid-FRAME -> outputs unchanged until the EOF beat, then applied the next cycle; two writes inside one frame -> only the second is applied.
REQ-035 SOF with tready=0 -> no state change; the same beat repeated with tready=1 -> FRAME.
REQ-036 Toggle aclk_grab_queue_en with level=2 -> level 0 the next cycle and the active context unchanged; reset asserted mid-FRAME -> all outputs at reset values and frame_active=0.
